nla_poly_seq_ctrl: RTL and testbench
====================================

// Module: nla_poly_seq_ctrl
// PURPOSE
//  Parametrised sequencer for the non-linear approximation datapath. Evaluates a polynomial per
//  sample by Horner iteration over a batch of samples.
//  Drives the signal/coefficient buffer reads, the accumulator reload (redo_*) and the result
//  load strobe.
//  Adds batching, selectable fixed-latency or handshake MAC completion, result backpressure,
//  abort, busy/done and index outputs.
// PARAMETERS
//  ADDR_LINES  4   width of coeff_count / coeff_idx (max polynomial order 2^ADDR_LINES-1)
//  SAMPLE_W    8   width of num_samples / sample_idx
//  MAC_LAT     13  fixed-mode cycles spent in WAIT per coefficient (>=1)
//  WAIT_W      5   width of internal wait counter (must hold MAC_LAT-1)
// PORTS
//  clk_i          in   1           clock, rising edge
//  rst_i          in   1           asynchronous, active-high reset
//  coeff_count    in   ADDR_LINES  number of Horner steps per sample, latched on start
//  num_samples    in   SAMPLE_W    samples per batch, latched on start (0 treated as 1)
//  mac_mode       in   1           0: fixed MAC_LAT wait; 1: wait for mac_done; latched on start
//  start_signal   in   1           signal buffer ready
//  start_coeff    in   1           coefficient buffer ready
//  mac_done       in   1           MAC step complete (honoured in WAIT when mode=1)
//  res_ready      in   1           downstream accepts result
//  abort          in   1           cancel batch
//  rd_en_signal   out  1           pop one sample from signal buffer
//  rd_en_coeff    out  1           pop one coefficient
//  redo_coeff     out  1           rewind coefficient buffer to entry 0
//  redo_data      out  1           0 = clear/reload accumulator this cycle
//  LD_result      out  1           result valid; held until res_ready
//  busy           out  1           state != IDLE
//  done           out  1           one-cycle pulse, batch complete
//  coeff_idx      out  ADDR_LINES  coefficients already consumed for current sample
//  sample_idx     out  SAMPLE_W    current sample index, 0-based
// BEHAVIOUR
//  - Reset (async, rst_i=1): state=IDLE, all counters 0; outputs 0 except redo_data=1.
//  - Outputs are decoded from the registered state (Moore), plus res_ready gating of the
//    EMIT exit only; no input->output combinational path.
//  - States:
//    - IDLE: wait for start_signal & start_coeff. Then latch coeff_count/num_samples/mac_mode,
//      zero sample_idx, go LOAD.
//    - LOAD: rd_en_signal=1, redo_coeff=1; coeff_left<=coeff_cnt_l, coeff_idx<=0; -> PRIME.
//    - PRIME: redo_data=0 (accumulator reload); -> CHECK.
//    - CHECK: coeff_left==0 -> EMIT, else -> FETCH.
//    - FETCH: rd_en_coeff=1; coeff_left-=1, coeff_idx+=1, wait_cnt<=0; -> WAIT.
//    - WAIT: mode0: exit to CHECK when wait_cnt==MAC_LAT-1, else wait_cnt+=1.
//      mode1: exit to CHECK on the cycle mac_done=1. mac_done outside WAIT is ignored.
//    - EMIT: LD_result=1 until the cycle res_ready=1. Then if sample_idx==last -> DONE,
//      else sample_idx+=1 -> LOAD.
//    - DONE: done=1 for one cycle; -> IDLE.
//  - Fixed-mode latency per sample, C=coeff_count: 2 + C*(2+MAC_LAT) + 1 + 1 cycles from
//    LOAD to EMIT exit (res_ready held 1).
//  - abort=1 in any non-IDLE state: next state IDLE, counters cleared, no LD_result or done
//    pulse. Abort has priority over every other transition.
//  - abort in IDLE ignored; start while busy ignored.
//  - coeff_count=0: LOAD,PRIME,CHECK,EMIT only (result = reloaded accumulator).
//  - num_samples=0 runs exactly one sample. sample_idx never wraps within a batch.
//  - Counters are unsigned, modulo their width. Latched configuration is stable for the whole
//    batch regardless of input changes.
// STRUCTURE
//  - Shared package nla_pkg: state encoding localparams (IDLE..DONE, 3 bits), MODE_FIXED/MODE_HS.
//  - Single flat module; the WAIT counter may be a sub-module nla_lat_counter (load, en, hit
//    at MAC_LAT-1).
// TESTING
//  1. Reset mid-WAIT (rst_i pulse) -> next edge busy=0, redo_data=1, all other outputs 0.
//  2. Mode0, coeff_count=3, num_samples=1, res_ready=1:
//     -> 3 rd_en_coeff pulses 15 cycles apart; LD_result at cycle 2+3*15+1=48 after LOAD;
//        done next cycle.
//  3. Mode1, coeff_count=2, mac_done after 4 and 9 cycles:
//     -> WAIT exits exactly on each mac_done; spurious mac_done in IDLE has no effect.
//  4. num_samples=3, coeff_count=1:
//     -> rd_en_signal x3, sample_idx 0,1,2; one done pulse. With res_ready low 5 cycles,
//        LD_result holds 5 cycles.
//  5. abort asserted in FETCH -> IDLE next cycle, no LD_result/done; a new start runs cleanly
//     from sample_idx=0.
//  6. coeff_count=0, num_samples=0 -> LOAD,PRIME,CHECK,EMIT,DONE; zero rd_en_coeff.

Source files
------------

// File: rtl/nla_pkg.sv
// Shared definitions for the non-linear approximation sequencer: FSM state
// encoding and MAC completion mode selectors.
package nla_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_PRIME = 3'd2,
        ST_CHECK = 3'd3,
        ST_FETCH = 3'd4,
        ST_WAIT  = 3'd5,
        ST_EMIT  = 3'd6,
        ST_DONE  = 3'd7
    } state_e;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_HS    = 1'b1;

endpackage

// File: rtl/nla_poly_seq_ctrl_if.sv
// Control/status bundle between the polynomial sequencer and its surroundings:
// configuration, buffer handshakes, MAC completion and result strobes.
interface nla_poly_seq_ctrl_if #(
    parameter int ADDR_LINES = 4,
    parameter int SAMPLE_W   = 8
);
    logic [ADDR_LINES-1:0] coeff_count;
    logic [SAMPLE_W-1:0]   num_samples;
    logic                  mac_mode;
    logic                  start_signal;
    logic                  start_coeff;
    logic                  mac_done;
    logic                  res_ready;
    logic                  abort;

    logic                  rd_en_signal;
    logic                  rd_en_coeff;
    logic                  redo_coeff;
    logic                  redo_data;
    logic                  LD_result;
    logic                  busy;
    logic                  done;
    logic [ADDR_LINES-1:0] coeff_idx;
    logic [SAMPLE_W-1:0]   sample_idx;

    modport master (
        output coeff_count, num_samples, mac_mode, start_signal, start_coeff,
               mac_done, res_ready, abort,
        input  rd_en_signal, rd_en_coeff, redo_coeff, redo_data, LD_result,
               busy, done, coeff_idx, sample_idx
    );

    modport slave (
        input  coeff_count, num_samples, mac_mode, start_signal, start_coeff,
               mac_done, res_ready, abort,
        output rd_en_signal, rd_en_coeff, redo_coeff, redo_data, LD_result,
               busy, done, coeff_idx, sample_idx
    );
endinterface

// File: rtl/nla_lat_counter.sv
// Fixed-latency MAC wait counter: cleared on load, counts while enabled and
// saturates at MAC_LAT-1, where o_hit is raised.
module nla_lat_counter #(
    parameter int MAC_LAT = 13,
    parameter int WAIT_W  = 5
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_load,
    input  logic i_en,
    output logic o_hit
);
    localparam logic [WAIT_W-1:0] HIT_VAL = WAIT_W'(MAC_LAT - 1);

    logic [WAIT_W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_en && !o_hit) begin
            r_cnt <= r_cnt + WAIT_W'(1);
        end
    end

    assign o_hit = (r_cnt == HIT_VAL);

endmodule

// File: rtl/nla_poly_seq_ctrl.sv
// Horner-iteration sequencer: walks a batch of samples, fetching coefficients
// and pacing MAC steps, with result backpressure, abort and status outputs.
module nla_poly_seq_ctrl
    import nla_pkg::*;
#(
    parameter int ADDR_LINES = 4,
    parameter int SAMPLE_W   = 8,
    parameter int MAC_LAT    = 13,
    parameter int WAIT_W     = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    nla_poly_seq_ctrl_if.slave bus
);
    state_e                r_state;
    state_e                w_state_nxt;

    logic [ADDR_LINES-1:0] r_coeff_cnt;
    logic [ADDR_LINES-1:0] r_coeff_left;
    logic [ADDR_LINES-1:0] r_coeff_idx;
    logic [SAMPLE_W-1:0]   r_last_idx;
    logic [SAMPLE_W-1:0]   r_sample_idx;
    logic                  r_mode;

    logic                  r_rd_en_signal;
    logic                  r_rd_en_coeff;
    logic                  r_redo_coeff;
    logic                  r_redo_data;
    logic                  r_ld_result;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_start;
    logic                  w_abort;
    logic                  w_lat_hit;
    logic                  w_mac_exit;
    logic                  w_last_sample;

    assign w_start       = bus.start_signal & bus.start_coeff;
    assign w_abort       = bus.abort & (r_state != ST_IDLE);
    assign w_last_sample = (r_sample_idx == r_last_idx);
    assign w_mac_exit    = (r_mode == MODE_HS) ? bus.mac_done : w_lat_hit;

    nla_lat_counter #(
        .MAC_LAT (MAC_LAT),
        .WAIT_W  (WAIT_W)
    ) u_lat_counter (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .i_load (r_state == ST_FETCH),
        .i_en   (r_state == ST_WAIT),
        .o_hit  (w_lat_hit)
    );

    // NOTE: the next-state value is defaulted before the case so that every
    // path assigns it and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        if (w_abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (w_start) w_state_nxt = ST_LOAD;
                ST_LOAD:  w_state_nxt = ST_PRIME;
                ST_PRIME: w_state_nxt = ST_CHECK;
                ST_CHECK: w_state_nxt = (r_coeff_left == '0) ? ST_EMIT : ST_FETCH;
                ST_FETCH: w_state_nxt = ST_WAIT;
                ST_WAIT:  if (w_mac_exit) w_state_nxt = ST_CHECK;
                ST_EMIT:  if (bus.res_ready) w_state_nxt = w_last_sample ? ST_DONE : ST_LOAD;
                ST_DONE:  w_state_nxt = ST_IDLE;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state, so they always decode the
    // state the FSM is currently in without any input-to-output path.
    // NOTE: every register here is a control flop with a defined reset value;
    // redo_data is active-low and therefore resets to 1.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state        <= ST_IDLE;
            r_coeff_cnt    <= '0;
            r_coeff_left   <= '0;
            r_coeff_idx    <= '0;
            r_last_idx     <= '0;
            r_sample_idx   <= '0;
            r_mode         <= MODE_FIXED;
            r_rd_en_signal <= 1'b0;
            r_rd_en_coeff  <= 1'b0;
            r_redo_coeff   <= 1'b0;
            r_redo_data    <= 1'b1;
            r_ld_result    <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_rd_en_signal <= (w_state_nxt == ST_LOAD);
            r_redo_coeff   <= (w_state_nxt == ST_LOAD);
            r_rd_en_coeff  <= (w_state_nxt == ST_FETCH);
            r_redo_data    <= (w_state_nxt != ST_PRIME);
            r_ld_result    <= (w_state_nxt == ST_EMIT);
            r_busy         <= (w_state_nxt != ST_IDLE);
            r_done         <= (w_state_nxt == ST_DONE);

            if (w_abort) begin
                r_coeff_left <= '0;
                r_coeff_idx  <= '0;
                r_sample_idx <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_start) begin
                            r_coeff_cnt  <= bus.coeff_count;
                            r_mode       <= bus.mac_mode;
                            r_sample_idx <= '0;
                            // An empty batch still runs a single sample.
                            r_last_idx   <= (bus.num_samples == '0) ? '0
                                          : bus.num_samples - SAMPLE_W'(1);
                        end
                    end
                    ST_LOAD: begin
                        r_coeff_left <= r_coeff_cnt;
                        r_coeff_idx  <= '0;
                    end
                    ST_FETCH: begin
                        r_coeff_left <= r_coeff_left - ADDR_LINES'(1);
                        r_coeff_idx  <= r_coeff_idx + ADDR_LINES'(1);
                    end
                    ST_EMIT: begin
                        if (bus.res_ready && !w_last_sample) begin
                            r_sample_idx <= r_sample_idx + SAMPLE_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.rd_en_signal = r_rd_en_signal;
    assign bus.rd_en_coeff  = r_rd_en_coeff;
    assign bus.redo_coeff   = r_redo_coeff;
    assign bus.redo_data    = r_redo_data;
    assign bus.LD_result    = r_ld_result;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.coeff_idx    = r_coeff_idx;
    assign bus.sample_idx   = r_sample_idx;

endmodule

// File: tb/tb_nla_poly_seq_ctrl.sv
// Bench for nla_poly_seq_ctrl: builds the expected per-cycle output trace of
// each batch from sample/coefficient loops and replays it against the DUT.
module tb_nla_poly_seq_ctrl;
    import nla_pkg::*;

    localparam int AL      = 4;
    localparam int SW      = 8;
    localparam int MAC_LAT = 13;
    localparam int WAIT_W  = 5;

    typedef struct {
        logic          st_sig, st_coef, mac_done, res_ready, abort;
        logic          rd_sig, rd_coef, redo_coef, redo_data, ld, busy, done;
        logic          c_care, s_care;
        logic [AL-1:0] cidx;
        logic [SW-1:0] sidx;
    } vec_t;

    typedef struct {
        int c;
        int n;
        bit mode;
        int stall;
        int abort_at;
    } cfg_t;

    logic clk_i = 1'b0;
    logic rst_i;
    int   n_vec = 0;
    int   n_err = 0;
    vec_t q[$];

    always #5 clk_i = ~clk_i;

    nla_poly_seq_ctrl_if #(.ADDR_LINES(AL), .SAMPLE_W(SW)) bus ();

    nla_poly_seq_ctrl #(
        .ADDR_LINES (AL),
        .SAMPLE_W   (SW),
        .MAC_LAT    (MAC_LAT),
        .WAIT_W     (WAIT_W)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pack_act(input logic cc, input logic sc);
        return {13'd0, bus.rd_en_signal, bus.rd_en_coeff, bus.redo_coeff, bus.redo_data,
                bus.LD_result, bus.busy, bus.done,
                cc ? bus.coeff_idx : {AL{1'b0}}, sc ? bus.sample_idx : {SW{1'b0}}};
    endfunction

    function automatic logic [31:0] pack_exp(input vec_t v);
        return {13'd0, v.rd_sig, v.rd_coef, v.redo_coef, v.redo_data, v.ld, v.busy, v.done,
                v.c_care ? v.cidx : {AL{1'b0}}, v.s_care ? v.sidx : {SW{1'b0}}};
    endfunction

    function automatic vec_t idle_v();
        vec_t v;
        v.st_sig = 1'b0; v.st_coef = 1'b0; v.abort = 1'b0;
        v.mac_done = 1'($urandom); v.res_ready = 1'($urandom);
        v.rd_sig = 1'b0; v.rd_coef = 1'b0; v.redo_coef = 1'b0; v.redo_data = 1'b1;
        v.ld = 1'b0; v.busy = 1'b0; v.done = 1'b0;
        v.c_care = 1'b0; v.s_care = 1'b0; v.cidx = '0; v.sidx = '0;
        return v;
    endfunction

    // Busy cycle with noise on every input the current step must ignore.
    function automatic vec_t busy_v(input int cidx, input int sidx, input bit c_care);
        vec_t v;
        v = idle_v();
        v.st_sig = 1'($urandom); v.st_coef = 1'($urandom);
        v.busy = 1'b1; v.c_care = c_care; v.s_care = 1'b1;
        v.cidx = AL'(cidx); v.sidx = SW'(sidx);
        return v;
    endfunction

    task automatic build_run(input int c, input int n, input bit mode, input int stall,
                             input int abort_at);
        vec_t v;
        int   last, w, st, ab;
        q.delete();
        v = idle_v(); v.st_sig = 1'b1; v.abort = 1'b1; q.push_back(v);
        v = idle_v(); v.st_sig = 1'b1; v.st_coef = 1'b1; q.push_back(v);
        last = (n == 0) ? 0 : n - 1;
        for (int s = 0; s <= last; s++) begin
            v = busy_v(0, s, 1'b0); v.rd_sig = 1'b1; v.redo_coef = 1'b1; q.push_back(v);
            v = busy_v(0, s, 1'b1); v.redo_data = 1'b0; q.push_back(v);
            for (int k = 1; k <= c; k++) begin
                v = busy_v(k - 1, s, 1'b1); q.push_back(v);
                v = busy_v(k - 1, s, 1'b1); v.rd_coef = 1'b1; q.push_back(v);
                w = (mode == MODE_HS) ? int'($urandom_range(1, 6)) : MAC_LAT;
                for (int j = 1; j <= w; j++) begin
                    v = busy_v(k, s, 1'b1);
                    if (mode == MODE_HS) v.mac_done = (j == w);
                    q.push_back(v);
                end
            end
            v = busy_v(c, s, 1'b1); q.push_back(v);
            st = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
            for (int j = 0; j <= st; j++) begin
                v = busy_v(c, s, 1'b1); v.ld = 1'b1; v.res_ready = (j == st);
                q.push_back(v);
            end
        end
        v = busy_v(c, last, 1'b1); v.done = 1'b1; q.push_back(v);
        v = idle_v(); q.push_back(v);
        if (abort_at != -1) begin
            ab = (abort_at == -2) ? int'($urandom_range(2, q.size() - 3)) : abort_at;
            q[ab].abort = 1'b1;
            while (q.size() > ab + 1) void'(q.pop_back());
            v = idle_v(); v.c_care = 1'b1; v.s_care = 1'b1; q.push_back(v);
            v = idle_v(); q.push_back(v);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        bus.start_signal = 1'b0; bus.start_coeff = 1'b0; bus.abort = 1'b0;
        bus.mac_done = 1'b0; bus.res_ready = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic apply(input int run_id, input int limit, input int c, input int n,
                         input bit mode);
        bit bad;
        int e0;
        bad = 1'b0;
        for (int i = 0; i < q.size() && i < limit; i++) begin
            @(negedge clk_i);
            if (!bad) begin
                e0 = n_err;
                check($sformatf("run%0d cyc%0d", run_id, i),
                      pack_act(q[i].c_care, q[i].s_care), pack_exp(q[i]));
                if (n_err != e0) bad = 1'b1;
            end
            bus.start_signal = q[i].st_sig;
            bus.start_coeff  = q[i].st_coef;
            bus.mac_done     = q[i].mac_done;
            bus.res_ready    = q[i].res_ready;
            bus.abort        = q[i].abort;
            if (q[i].st_sig && q[i].st_coef && !q[i].busy) begin
                bus.coeff_count = AL'(c);
                bus.num_samples = SW'(n);
                bus.mac_mode    = mode;
            end else begin
                bus.coeff_count = AL'($urandom);
                bus.num_samples = SW'($urandom);
                bus.mac_mode    = 1'($urandom);
            end
        end
        if (bad) do_reset();
    endtask

    // Asynchronous reset landing in the middle of a fixed-latency WAIT.
    task automatic reset_mid_wait();
        build_run(3, 1, MODE_FIXED, 0, -1);
        apply(900, 10, 3, 1, MODE_FIXED);
        @(posedge clk_i);
        #1 check("busy_before_reset", {31'd0, bus.busy}, 32'd1);
        #1 rst_i = 1'b1;
        #1 check("async_reset", pack_act(1'b1, 1'b1), {13'd0, 7'b0001000, {AL{1'b0}}, {SW{1'b0}}});
        bus.start_signal = 1'b0; bus.start_coeff = 1'b0; bus.abort = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    // Fixed mode, C=3, one sample: coefficient spacing and LOAD-to-EMIT latency.
    task automatic latency_run();
        int t, t_load, t_ld, nco, last_co;
        @(negedge clk_i);
        bus.coeff_count = AL'(3); bus.num_samples = SW'(1); bus.mac_mode = MODE_FIXED;
        bus.res_ready = 1'b1; bus.mac_done = 1'b0; bus.abort = 1'b0;
        bus.start_signal = 1'b1; bus.start_coeff = 1'b1;
        t = 0; t_load = -1; t_ld = -1; nco = 0; last_co = -1;
        while (t < 200 && t_ld < 0) begin
            @(negedge clk_i);
            t++;
            bus.start_signal = 1'b0; bus.start_coeff = 1'b0;
            if (bus.rd_en_signal && t_load < 0) t_load = t;
            if (bus.rd_en_coeff) begin
                if (last_co >= 0) check("coeff_gap", t - last_co, 2 + MAC_LAT);
                last_co = t;
                nco++;
            end
            if (bus.LD_result) t_ld = t;
        end
        check("ld_latency", (t_ld < 0 || t_load < 0) ? -1 : t_ld - t_load,
              2 + 3 * (2 + MAC_LAT) + 1);
        check("coeff_pulses", nco, 3);
        @(negedge clk_i);
        check("done_pulse", {31'd0, bus.done}, 32'd1);
        @(negedge clk_i);
        check("idle_after_done", {30'd0, bus.busy, bus.done}, 32'd0);
    endtask

    initial begin
        cfg_t tbl[10];
        cfg_t cf;
        tbl[0] = '{3, 1,   MODE_FIXED, -1, -1};
        tbl[1] = '{2, 1,   MODE_HS,    -1, -1};
        tbl[2] = '{1, 3,   MODE_FIXED,  5, -1};
        tbl[3] = '{0, 0,   MODE_FIXED, -1, -1};
        tbl[4] = '{0, 0,   MODE_HS,    -1, -1};
        tbl[5] = '{2, 2,   MODE_FIXED, -1,  5};
        tbl[6] = '{1, 1,   MODE_HS,    -1, -1};
        tbl[7] = '{15, 1,  MODE_HS,     0, -1};
        tbl[8] = '{3, 0,   MODE_HS,     2, -1};
        tbl[9] = '{0, 255, MODE_HS,     0, -1};

        rst_i = 1'b1;
        bus.coeff_count = '0; bus.num_samples = '0; bus.mac_mode = 1'b0;
        bus.start_signal = 1'b0; bus.start_coeff = 1'b0; bus.mac_done = 1'b0;
        bus.res_ready = 1'b0; bus.abort = 1'b0;
        #12;
        check("reset_state", pack_act(1'b1, 1'b1), {13'd0, 7'b0001000, {AL{1'b0}}, {SW{1'b0}}});
        @(negedge clk_i);
        rst_i = 1'b0;

        reset_mid_wait();
        latency_run();

        for (int r = 0; r < 10; r++) begin
            build_run(tbl[r].c, tbl[r].n, tbl[r].mode, tbl[r].stall, tbl[r].abort_at);
            apply(r, 1 << 30, tbl[r].c, tbl[r].n, tbl[r].mode);
        end

        for (int r = 10; r < 40; r++) begin
            cf.c        = int'($urandom_range(0, 6));
            cf.n        = int'($urandom_range(0, 4));
            cf.mode     = 1'($urandom_range(0, 1));
            cf.stall    = -1;
            cf.abort_at = ($urandom_range(0, 3) == 0) ? -2 : -1;
            build_run(cf.c, cf.n, cf.mode, cf.stall, cf.abort_at);
            apply(r, 1 << 30, cf.c, cf.n, cf.mode);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
